// File: rtl/apb_pkg.sv
// Shared APB definitions: requester state encoding and default bus widths.
package apb_pkg;
    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_req_state_e;
endpackage

// File: rtl/apb_requester_if.sv
// APB bus bundle; the requester uses the master modport, the completer the slave modport.
interface apb_requester_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready
    );
endinterface

// File: rtl/apb_requester.sv
// APB requester: turns a valid/ready command stream into single APB transfers
// and returns read data / write completion (or a timeout) on a response stream.
module apb_requester
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,
    apb_requester_if.master   apb
);
    localparam int CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    apb_req_state_e    state_q, state_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              tmo_q, tmo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tmo_hit;

    // Abort on the TIMEOUT-th idle ACCESS cycle; a simultaneous pready wins.
    assign tmo_hit = (TIMEOUT != 0) && !apb.pready && (cnt_q == CNT_W'(TMO_LAST));

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd_valid) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (apb.pready || tmo_hit) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE && cmd_valid) begin
            write_d = cmd_write;
            addr_d  = cmd_addr;
            wdata_d = cmd_wdata;
        end
        if (state_q == SETUP) begin
            cnt_d = '0;
        end
        if (state_q == ACCESS) begin
            if (apb.pready) begin
                rdata_d = write_q ? '0 : apb.prdata;
                tmo_d   = 1'b0;
            end else begin
                if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
                if (tmo_hit) begin
                    rdata_d = '0;
                    tmo_d   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        cmd_ready   = (state_q == IDLE);
        apb.psel    = (state_q == SETUP) || (state_q == ACCESS);
        apb.penable = (state_q == ACCESS);
        rsp_valid   = (state_q == RESP);
        apb.pwrite  = write_q;
        apb.paddr   = addr_q;
        apb.pwdata  = wdata_q;
        rsp_rdata   = rdata_q;
        rsp_timeout = tmo_q;
    end
endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester with a memory-backed APB completer and protocol checks.
module tb_apb_requester;
    logic       pclk = 1'b0;
    logic       presetn;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [7:0] cmd_addr, cmd_wdata;
    logic       rsp_valid, rsp_ready, rsp_timeout;
    logic [7:0] rsp_rdata;

    int n_cmp = 0;
    int n_err = 0;

    logic       stuck;
    int         wait_n;
    int         wcnt;
    logic [7:0] mem [256];
    logic [7:0] mdl [256];

    apb_requester_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    apb_requester #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(4)) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_timeout (rsp_timeout),
        .apb         (bus)
    );

    always #5 pclk = ~pclk;

    // Completer: wait_n wait states per access unless stuck; register file reset to i^A5.
    assign bus.pready = bus.psel & bus.penable & ~stuck & (wcnt == wait_n);
    assign bus.prdata = mem[bus.paddr];

    always @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wcnt <= 0;
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hA5;
        end else begin
            if (bus.psel && bus.penable && !bus.pready) wcnt <= wcnt + 1;
            else wcnt <= 0;
            if (bus.psel && bus.penable && bus.pready && bus.pwrite) mem[bus.paddr] <= bus.pwdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic       prev_psel, prev_pen;
    logic [7:0] prev_addr;
    always @(negedge pclk) begin
        if (presetn) begin
            if (bus.penable) chk("apb_en_needs_sel", 32'(bus.psel), 32'd1);
            if (prev_psel && !prev_pen) begin
                chk("apb_setup_to_access", 32'({bus.psel, bus.penable}), 32'd3);
                chk("apb_addr_stable", 32'(bus.paddr), 32'(prev_addr));
            end
        end
        prev_psel <= bus.psel & presetn;
        prev_pen  <= bus.penable & presetn;
        prev_addr <= bus.paddr;
    end

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    initial begin
        logic       w;
        logic [7:0] a, d, e;
        int         k;

        presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
        rsp_ready = 1'b1; stuck = 1'b0; wait_n = 0;
        for (int i = 0; i < 256; i++) mdl[i] = 8'(i) ^ 8'hA5;
        repeat (3) step();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_psel_pen_pwrite", 32'({bus.psel, bus.penable, bus.pwrite}), 32'd0);
        chk("rst_paddr_pwdata", 32'({bus.paddr, bus.pwdata}), 32'd0);
        chk("rst_rsp", 32'({rsp_valid, rsp_rdata, rsp_timeout}), 32'd0);
        presetn = 1'b1;
        step();

        // Reset in the middle of a stalled ACCESS drops the transfer.
        stuck = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h01;
        step();
        cmd_valid = 1'b0;
        step();
        chk("rst_pre_access", 32'({bus.psel, bus.penable}), 32'd3);
        presetn = 1'b0;
        #1;
        chk("rst_mid_psel_pen", 32'({bus.psel, bus.penable}), 32'd0);
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
        step();
        presetn = 1'b1; stuck = 1'b0;
        k = 0;
        repeat (6) begin
            step();
            if (rsp_valid) k++;
        end
        chk("rst_no_rsp_after", 32'(k), 32'd0);

        // Zero-wait write 0x5A -> 0x00.
        wait_n = 0; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h00; cmd_wdata = 8'h5A;
        step();
        cmd_valid = 1'b0;
        chk("wr_setup", 32'({bus.psel, bus.penable, bus.pwrite, cmd_ready}), 32'b1010);
        chk("wr_setup_addr_data", 32'({bus.paddr, bus.pwdata}), 32'h005A);
        step();
        chk("wr_access", 32'({bus.psel, bus.penable, rsp_valid}), 32'b110);
        step();
        chk("wr_rsp", 32'({rsp_valid, bus.psel, rsp_rdata, rsp_timeout}), {22'd0, 1'b1, 1'b0, 8'h00, 1'b0});
        step();
        chk("wr_idle", 32'({cmd_ready, rsp_valid}), 32'b10);
        mdl[0] = 8'h5A;

        // Read 0x02 with 3 wait states.
        wait_n = 3; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h02;
        step();
        cmd_valid = 1'b0;
        chk("rd_setup", 32'({bus.psel, bus.penable}), 32'b10);
        k = 0;
        repeat (4) begin
            step();
            if (bus.psel && bus.penable && !rsp_valid) k++;
        end
        chk("rd_access_cycles", 32'(k), 32'd4);
        step();
        chk("rd_rsp_t6", 32'({rsp_valid, rsp_rdata, rsp_timeout}), {23'd0, 1'b1, 8'hA7, 1'b0});
        step();

        // Timeout with pready stuck low.
        stuck = 1'b1; wait_n = 0; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h05;
        step();
        cmd_valid = 1'b0;
        k = 0;
        repeat (5) begin
            step();
            if (bus.psel && bus.penable) k++;
        end
        chk("tmo_access_cycles", 32'(k), 32'd4);
        chk("tmo_rsp", 32'({rsp_valid, bus.psel, rsp_rdata, rsp_timeout}), {22'd0, 1'b1, 1'b0, 8'h00, 1'b1});
        step();
        stuck = 1'b0;

        // Backpressure on a read of 0x00 (previously written 0x5A).
        rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h00;
        step();
        cmd_valid = 1'b0;
        repeat (2) step();
        k = 0;
        repeat (5) begin
            if (rsp_valid && !cmd_ready && rsp_rdata == 8'h5A && !rsp_timeout) k++;
            step();
        end
        chk("bp_stable_cycles", 32'(k), 32'd5);
        rsp_ready = 1'b1;
        chk("bp_still_valid", 32'({rsp_valid, rsp_rdata}), 32'h15A);
        step();
        chk("bp_idle", 32'({cmd_ready, rsp_valid}), 32'b10);

        // Back-to-back random traffic against the register model.
        cmd_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            w = 1'($urandom_range(0, 1));
            a = 8'($urandom_range(0, 7));
            d = 8'($urandom);
            wait_n = int'($urandom_range(0, 2));
            cmd_write = w; cmd_addr = a; cmd_wdata = d;
            chk("b2b_cmd_ready", 32'(cmd_ready), 32'd1);
            step();
            k = 0;
            while (!rsp_valid && k < 20) begin
                step();
                k++;
            end
            e = w ? 8'h00 : mdl[a];
            if (w) mdl[a] = d;
            chk("b2b_rsp_seen", 32'(rsp_valid), 32'd1);
            chk("b2b_rsp_data", 32'({rsp_rdata, rsp_timeout}), 32'({e, 1'b0}));
            step();
        end
        cmd_valid = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/apb_requester.md
# apb_requester

APB requester (master) that drives the timer's APB completer port from a simple valid/ready command stream. It issues one transfer at a time and returns read data, or write completion, on a valid/ready response stream. A wait-state timeout prevents a hung completer from stalling the system. It sits between the test/firmware command source and the 8-bit APB bus: `pclk`, `presetn`, `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `prdata`, `pready`.

## Interface
Parameters:
- `ADDR_W`, default 8: APB address width.
- `DATA_W`, default 8: APB data width.
- `TIMEOUT`, default 16: maximum number of ACCESS cycles with `pready`=0 before the transfer is aborted; 0 disables the timeout.

Ports (one clock; reset is asynchronous and active-low):
- `pclk`  in  1  APB clock; all logic on its rising edge.
- `presetn`  in  1  asynchronous active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when high together with `cmd_valid`.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_W  target address.
- `cmd_wdata`  in  DATA_W  write data; ignored for reads.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed when high together with `rsp_valid`.
- `rsp_rdata`  out  DATA_W  read data; 0 for writes and timeouts.
- `rsp_timeout`  out  1  transfer aborted by timeout.
- `psel`  out  1  APB select.
- `penable`  out  1  APB enable.
- `pwrite`  out  1  APB write.
- `paddr`  out  ADDR_W  APB address.
- `pwdata`  out  DATA_W  APB write data.
- `prdata`  in  DATA_W  APB read data.
- `pready`  in  1  APB completer ready.

## Operation
State machine states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`: latch write/addr/wdata and go to SETUP.
- SETUP (exactly 1 cycle):
  - `psel`=1, `penable`=0.
  - `paddr`/`pwrite`/`pwdata` driven from the latched command.
  - Always go to ACCESS.
- ACCESS:
  - `psel`=1, `penable`=1; address/control/data held stable.
  - Wait counter clears on entry and increments each cycle `pready`=0.
  - `pready`=1: capture `prdata` (reads) or 0 (writes), clear the timeout flag, go to RESP.
  - Counter reaches `TIMEOUT` (when `TIMEOUT`≠0) with `pready`=0: abort. Set `rsp_timeout`=1 and `rsp_rdata`=0, go to RESP.
- RESP:
  - `psel`=`penable`=0; `rsp_valid`=1.
  - Response held stable until `rsp_ready`, then go to IDLE.
- Counter width is `$clog2(TIMEOUT+1)`; the counter saturates and never wraps.
- `paddr`/`pwrite`/`pwdata` are registered and keep their last values outside transfers.
- `pready` and `prdata` are ignored outside ACCESS.
- `cmd_ready` is low in SETUP, ACCESS and RESP. Only one outstanding transfer; no pipelining.

## Timing
- Reset values:
  - State IDLE.
  - `cmd_ready`=1; `psel`=`penable`=`pwrite`=0.
  - `paddr`=0, `pwdata`=0.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_timeout`=0.
  - Wait counter 0.
- Command accepted at edge T:
  - SETUP in cycle T+1, ACCESS from T+2.
  - `pready`=1 sampled at the end of T+2 → `rsp_valid` in T+3.
- With zero wait states and `rsp_ready` tied high: 4 cycles per transfer; next `cmd_ready` in T+4.
- Each wait state adds exactly 1 cycle.
- Timeout: `rsp_valid` in the cycle after the `TIMEOUT`-th consecutive `pready`=0 ACCESS cycle.
- If `pready` rises in the same cycle the counter hits `TIMEOUT`, `pready` wins and the transfer completes normally.
- Reset asserted mid-transfer:
  - All outputs return immediately to reset values.
  - The in-flight command is dropped; no response is produced.
- `rsp_valid` is not dropped without `rsp_ready`.

## Structure
- Shared package `apb_pkg`:
  - State typedef `apb_req_state_e` {IDLE, SETUP, ACCESS, RESP}.
  - Default `ADDR_W`/`DATA_W` constants.
- Single module; no sub-module. The wait counter is local logic.

## Test plan
- Reset: hold `presetn`=0 mid-ACCESS → `psel`/`penable`/`rsp_valid`=0 and `cmd_ready`=1 immediately; after release, no response appears.
- Zero-wait write: cmd write addr 0x00, data 0x5A, `pready` tied 1 → `psel` high 2 cycles with `penable` high in the 2nd; `paddr`=0x00, `pwdata`=0x5A; `rsp_valid` at T+3 with `rsp_rdata`=0 and `rsp_timeout`=0.
- Wait-state read: read addr 0x02, `pready` low 3 cycles, then high with `prdata`=0xA7 → ACCESS lasts 4 cycles; `rsp_rdata`=0xA7 with `rsp_valid` at T+6.
- Timeout: `TIMEOUT`=4, `pready` stuck 0 → `psel` drops after 4 ACCESS cycles; `rsp_timeout`=1, `rsp_rdata`=0.
- Backpressure: hold `rsp_ready`=0 for 5 cycles → `rsp_valid` and the response stay stable; `cmd_ready`=0 throughout; IDLE one cycle after `rsp_ready`=1.
- Back-to-back: 16 random read/write commands with `cmd_valid` held high and random wait states → APB protocol checker clean; responses in order and matching a scoreboard model of the timer registers.
